// File: rtl/mycpu_pkg.sv
// Shared load-path types for the mycpu core: access sizes, load modes, queue entry layout.
// LOAD_ALIGN_MERGE_EN adds the stored old register value to each entry and legalises LWL/LWR.
package mycpu_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        LWL    = 2'd1,
        LWR    = 2'd2
    } load_mode_t;

    typedef struct packed {
        msize_t     msize;
        logic       sig;
        load_mode_t mode;
        logic [31:0] addr;
    } memory_args_t;

    localparam int LQ_MAX_DATA_W = 64;

    typedef struct packed {
        memory_args_t              args;
        logic [4:0]                dst;
`ifdef LOAD_ALIGN_MERGE_EN
        logic [31:0]               old;
`endif
        logic [LQ_MAX_DATA_W-1:0]  data;
        logic                      done;
    } lq_entry_t;

    // Misaligned or unsupported request for a memory port of width data_w.
    function automatic logic lq_illegal(input memory_args_t a, input int data_w);
        logic bad;
        bad = 1'b0;
        case (a.mode)
            NORMAL: begin
                case (a.msize)
                    MSIZE1:  bad = 1'b0;
                    MSIZE2:  bad = a.addr[0];
                    MSIZE4:  bad = |a.addr[1:0];
                    MSIZE8:  bad = (|a.addr[2:0]) || (data_w == 32'sd32);
                    default: bad = 1'b1;
                endcase
            end
`ifdef LOAD_ALIGN_MERGE_EN
            LWL, LWR: bad = 1'b0;
`else
            LWL, LWR: bad = 1'b1;
`endif
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Combinational lane select, sign/zero extension and (with LOAD_ALIGN_MERGE_EN) LWL/LWR merge
// of a raw memory beat into a 32-bit writeback value.
module load_lane_extract
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  memory_args_t               args,
    input  logic [31:0]                old,
    input  logic [LQ_MAX_DATA_W-1:0]   raw,
    output logic [31:0]                out
);

    logic [31:0] word_s;
    logic [31:0] lane_s;
    logic [4:0]  shift_s;
    logic        unused_s;

    // A 64-bit beat carries two words; addr[2] picks which one the load targets.
    assign word_s   = ((DATA_W == 32'sd64) && args.addr[2]) ? raw[63:32] : raw[31:0];
    assign shift_s  = {args.addr[1:0], 3'b000};
    assign lane_s   = word_s >> shift_s;
    assign unused_s = ^{args.addr[31:3], old};

`ifdef LOAD_ALIGN_MERGE_EN
    logic [31:0] mask_s;
`endif

    // Build the writeback value for the access size / mode.
    always_comb begin
        out = word_s;
`ifdef LOAD_ALIGN_MERGE_EN
        mask_s = 32'h0000_0000;
`endif
        case (args.mode)
            NORMAL: begin
                case (args.msize)
                    MSIZE1:  out = {{24{args.sig & lane_s[7]}}, lane_s[7:0]};
                    MSIZE2:  out = {{16{args.sig & lane_s[15]}}, lane_s[15:0]};
                    MSIZE4:  out = word_s;
                    MSIZE8:  out = word_s;
                    default: out = word_s;
                endcase
            end
`ifdef LOAD_ALIGN_MERGE_EN
            // Memory bytes o..0 land in the top of the register; the rest keeps old.
            LWL: begin
                mask_s = 32'hFFFF_FFFF << (5'd24 - shift_s);
                out    = ((word_s << (5'd24 - shift_s)) & mask_s) | (old & ~mask_s);
            end
            LWR: begin
                mask_s = 32'hFFFF_FFFF >> shift_s;
                out    = (lane_s & mask_s) | (old & ~mask_s);
            end
`endif
            default: out = word_s;
        endcase
    end

endmodule

// File: rtl/load_align_queue.sv
// In-order load queue: holds outstanding loads, matches memory beats in order and writes back
// aligned/extended data. Build macro LOAD_ALIGN_MERGE_EN enables LWL/LWR merging with req_old.
module load_align_queue
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  memory_args_t      req_args,
    input  logic [4:0]        req_dst,
    input  logic [31:0]       req_old,
    output logic              req_illegal,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [4:0]        out_dst,
    output logic              stray_resp
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    lq_entry_t   entries_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW-1:0] resp_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] pend_r;
    logic          stray_r;

    logic          push_s;
    logic          pop_s;
    logic          resp_hit_s;
    logic          out_valid_s;
    logic [31:0]   head_old_s;
    logic [31:0]   ext_s;

    assign req_illegal = lq_illegal(req_args, DATA_W);
    assign req_ready   = (count_r != CNT_FULL);
    assign push_s      = req_valid && req_ready && !req_illegal;
    assign resp_hit_s  = resp_valid && (pend_r != {CW{1'b0}});
    assign out_valid_s = (count_r != {CW{1'b0}}) && entries_r[head_r].done;
    assign pop_s       = out_valid_s && out_ready;

`ifdef LOAD_ALIGN_MERGE_EN
    assign head_old_s = entries_r[head_r].old;
`else
    assign head_old_s = 32'h0000_0000;
`endif

    load_lane_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .args (entries_r[head_r].args),
        .old  (head_old_s),
        .raw  (entries_r[head_r].data),
        .out  (ext_s)
    );

    // Head fields are frozen while done, so gating by out_valid keeps the output stable and zero otherwise.
    assign out_valid  = out_valid_s;
    assign out_data   = out_valid_s ? ext_s : 32'h0000_0000;
    assign out_dst    = out_valid_s ? entries_r[head_r].dst : 5'd0;
    assign stray_resp = stray_r;

    // Queue storage, pointers, occupancy and the sticky stray-response flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            resp_ptr_r <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            pend_r     <= {CW{1'b0}};
            stray_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                entries_r[tail_r].args <= req_args;
                entries_r[tail_r].dst  <= req_dst;
`ifdef LOAD_ALIGN_MERGE_EN
                entries_r[tail_r].old  <= req_old;
`endif
                entries_r[tail_r].done <= 1'b0;
                tail_r <= tail_r + PTR_ONE;
            end
            // A pending entry never shares its slot with the tail, so push and response cannot collide.
            if (resp_hit_s) begin
                entries_r[resp_ptr_r].data <= LQ_MAX_DATA_W'(resp_data);
                entries_r[resp_ptr_r].done <= 1'b1;
                resp_ptr_r <= resp_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            if (resp_valid && !resp_hit_s) begin
                stray_r <= 1'b1;
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
            pend_r  <= pend_r + CW'(push_s) - CW'(resp_hit_s);
        end
    end

`ifndef LOAD_ALIGN_MERGE_EN
    logic unused_s;
    assign unused_s = ^req_old;
`endif

endmodule

// File: doc/load_align_queue.md
LOAD_ALIGN_QUEUE -- requirements
Module: load_align_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning memory response width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, meaning maximum outstanding loads; a power of two, at least 2.
REQ-003 SHALL expose ports: clk in 1, single clock, rising edge; reset in 1, asynchronous, active-high.
REQ-004 SHALL expose req_valid in 1 and req_ready out 1; together they form the load-request handshake.
REQ-005 SHALL expose req_args in memory_args_t, carrying msize, sig, mode and addr (low OB = log2(DATA_W/8) bits used).
REQ-006 SHALL expose req_dst in 5 (destination register) and req_old in 32 (old register value, used for merges).
REQ-007 SHALL expose req_illegal out 1: combinational, the current request is misaligned or unsupported.
REQ-008 SHALL expose resp_valid in 1 and resp_data in DATA_W: the memory data_ok beat, which cannot be back-pressured.
REQ-009 SHALL expose out_valid out 1, out_ready in 1, out_data out 32 and out_dst out 5: the writeback handshake.
REQ-010 SHALL expose stray_resp out 1: sticky, set when a response arrives with no pending entry.

Function
REQ-011 SHALL enqueue an entry when req_valid & req_ready & !req_illegal; req_ready = !full, even during a same-cycle pop.
REQ-012 SHALL set req_illegal for the following requests, and never enqueue them:
- MSIZE2 with addr[0]!=0;
- MSIZE4 with addr[1:0]!=0;
- MSIZE8 with addr[2:0]!=0 or DATA_W=32.
REQ-013 SHALL match responses strictly in order: resp_valid writes resp_data into the oldest entry whose data has not yet arrived, and sets that entry's done bit.
REQ-014 SHALL drive out_valid from the head entry's done bit; a response captured at edge t gives out_valid=1 in cycle t+1 at the earliest.
REQ-015 SHALL pop the head on out_valid & out_ready, so throughput is one load per cycle.
REQ-016 SHALL derive out_data combinationally from head entry fields via the extract sub-module:
- select a byte, half or word lane at the addr offset;
- sign- or zero-extend per sig;
- for MSIZE8, return the low 32 bits.
REQ-017 SHALL, when DATA_W=64, select the 32-bit half by addr[2] before extraction.
REQ-018 SHALL handle a simultaneous push, response and pop in one cycle correctly; occupancy changes by push minus pop.
REQ-019 SHALL wrap the head, tail and response pointers modulo DEPTH; full and empty SHALL be distinguished by an occupancy counter of width log2(DEPTH)+1.
REQ-020 SHALL ignore a response when no entry is pending and set stray_resp; no entry SHALL be modified.
REQ-021 SHALL hold out_data and out_dst stable while out_valid & !out_ready.

Reset
REQ-022 SHALL, on asynchronous reset assertion, clear the occupancy counter, all pointers, all done bits and stray_resp.
REQ-023 SHALL drive these values under reset: out_valid=0, req_ready=1, stray_resp=0, out_data=0, out_dst=0.
REQ-024 SHALL discard all in-flight entries on a mid-operation reset; responses arriving after reset release SHALL count as stray.

Configuration
REQ-025 SHALL honour macro LOAD_ALIGN_MERGE_EN:
- Defined: mode LWL/LWR is accepted at any offset. out_data SHALL merge the memory word with the stored req_old (MIPS little-endian):
  - LWL offset o: bytes 3..3-o from memory bytes o..0, remaining low bytes from req_old;
  - LWR offset o: bytes 3-o..0 from memory bytes 3..o, remaining high bytes from req_old.
- Undefined: LWL/LWR requests SHALL assert req_illegal, and the req_old storage SHALL be omitted.

Structure
REQ-026 SHALL place the following in the shared mycpu package: MSIZE8, load_mode_t (NORMAL, LWL, LWR), and lq_entry_t (args, dst, old, data, done).
REQ-027 SHALL instantiate one combinational sub-module, load_lane_extract (args, old, raw, out), for alignment, extension and merge.

Verification
REQ-028 SHALL cover: LB sig, addr[1:0]=3, resp 0x80FF_1234 -> out_data 0xFFFF_FF80.
REQ-029 SHALL cover: LHU addr[1:0]=2, DATA_W=64, addr[2]=1, resp 0xBEEF_0000_0000_0000 -> out_data 0x0000_BEEF.
REQ-030 SHALL cover:
- DEPTH=4: four requests, no response -> req_ready=0;
- then four responses with out_ready=1 -> in-order dst writebacks, the first in the cycle after its response.
REQ-031 SHALL cover: LW addr[1:0]=2 -> req_illegal=1, no enqueue; response with queue empty -> stray_resp=1.
REQ-032 SHALL cover (LOAD_ALIGN_MERGE_EN): LWL offset 1, mem 0x4433_2211, old 0xAABB_CCDD -> out_data 0x2211_CCDD.
REQ-033 SHALL cover: reset asserted with 2 outstanding entries -> out_valid=0 in the same cycle, req_ready=1.
